// File: rtl/jts16b_snd_pkg.sv
// Shared constants for the sound-CPU side of the 315-5195 mailbox: IRQ FSM
// encoding, default Z80 I/O ports and status-register bit layout.
package jts16b_snd_pkg;

   typedef enum logic [1:0] {
      IRQ_IDLE = 2'd0,
      IRQ_PEND = 2'd1,
      IRQ_ACK  = 2'd2
   } irq_st_e;

   localparam logic [7:0] PORT_DATA_DEF = 8'h40;
   localparam logic [7:0] PORT_STAT_DEF = 8'h41;
   localparam logic [7:0] IRQ_VEC_DEF   = 8'hFF;
   localparam logic [3:0] NMI_LEN_DEF   = 4'd8;

   localparam int STAT_OBF   = 0;
   localparam int STAT_REPLY = 1;

   // Status port image; unused bits read as zero.
   function automatic logic [7:0] stat_byte(input logic reply, input logic obf);
      logic [7:0] s;
      s             = 8'd0;
      s[STAT_OBF]   = obf;
      s[STAT_REPLY] = reply;
      return s;
   endfunction

endpackage

// File: rtl/jts16b_snd_strobe.sv
// Z80 bus-cycle decoder: turns IORQ/RD/WR/M1 levels into one-clock strobes,
// one per access, sampled only on cen. Also flags an idle bus on cen.
module jts16b_snd_strobe (
   input  logic rst,
   input  logic clk,
   input  logic cen,
   input  logic iorqn_i,
   input  logic rdn_i,
   input  logic wrn_i,
   input  logic m1n_i,
   output logic io_rd_o,
   output logic io_wr_o,
   output logic inta_o,
   output logic bus_idle_o
);

   logic io_rd_lv, io_wr_lv, inta_lv;
   logic io_rd_q, io_wr_q, inta_q;

   assign io_rd_lv = ~iorqn_i & ~rdn_i & m1n_i;
   assign io_wr_lv = ~iorqn_i & ~wrn_i & m1n_i;
   assign inta_lv  = ~iorqn_i & ~m1n_i;

   // Previous levels only advance on cen, so a held cen still yields one strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io_rd_q <= 1'b0;
         io_wr_q <= 1'b0;
         inta_q  <= 1'b0;
      end else if (cen) begin
         io_rd_q <= io_rd_lv;
         io_wr_q <= io_wr_lv;
         inta_q  <= inta_lv;
      end
   end

   assign io_rd_o    = cen & io_rd_lv & ~io_rd_q;
   assign io_wr_o    = cen & io_wr_lv & ~io_wr_q;
   assign inta_o     = cen & inta_lv  & ~inta_q;
   assign bus_idle_o = cen & iorqn_i & m1n_i;

endmodule

// File: rtl/jts16b_sndlatch.sv
// Sound-CPU end of the 315-5195 mailbox: Z80 data/status ports, INT on byte
// arrival, reply path to the mapper. Optional NMI pulse with SNDLATCH_NMI_EN.
module jts16b_sndlatch
   import jts16b_snd_pkg::*;
#(
   parameter logic [7:0] PORT_DATA = PORT_DATA_DEF,
   parameter logic [7:0] PORT_STAT = PORT_STAT_DEF,
   parameter logic [7:0] IRQ_VEC   = IRQ_VEC_DEF
`ifdef SNDLATCH_NMI_EN
   ,
   parameter logic [3:0] NMI_LEN   = NMI_LEN_DEF
`endif
) (
   input  logic       rst,
   input  logic       clk,
   input  logic       cen,
   input  logic [7:0] sndmap_dout,
   input  logic       sndmap_obf,
   output logic       sndmap_rd,
   output logic       sndmap_wr,
   output logic [7:0] sndmap_din,
   input  logic [7:0] z80_addr,
   input  logic       z80_iorqn,
   input  logic       z80_rdn,
   input  logic       z80_wrn,
   input  logic       z80_m1n,
   input  logic [7:0] z80_dout,
   output logic [7:0] z80_din,
   output logic       z80_intn,
   output logic       z80_nmin,
   output logic [1:0] dbg_st_o
);

   localparam logic [1:0] ST_IDLE = IRQ_IDLE;
   localparam logic [1:0] ST_PEND = IRQ_PEND;
   localparam logic [1:0] ST_ACK  = IRQ_ACK;

   logic       rd_stb, wr_stb, inta_stb, bus_idle;
   logic       data_sel, stat_sel, data_rd, data_wr;
   logic       obf_q, obf_rise;
   logic [1:0] st_q, st_d;
   logic       rearm_q, rearm_d;
   logic       chk_q, chk_d;
   logic       reply_q, reply_d;
   logic [7:0] din_q, din_d;
   logic [7:0] rep_q, rep_d;
   logic       rd_q, wr_q;

   jts16b_snd_strobe u_strobe (
      .rst        (rst),
      .clk        (clk),
      .cen        (cen),
      .iorqn_i    (z80_iorqn),
      .rdn_i      (z80_rdn),
      .wrn_i      (z80_wrn),
      .m1n_i      (z80_m1n),
      .io_rd_o    (rd_stb),
      .io_wr_o    (wr_stb),
      .inta_o     (inta_stb),
      .bus_idle_o (bus_idle)
   );

   assign data_sel = (z80_addr == PORT_DATA);
   assign stat_sel = (z80_addr == PORT_STAT);
   assign data_rd  = rd_stb & data_sel;
   assign data_wr  = wr_stb & data_sel;
   assign obf_rise = sndmap_obf & ~obf_q;

   always_comb begin
      din_d = din_q;
      if (inta_stb) begin
         din_d = IRQ_VEC;
      end else if (rd_stb) begin
         if (data_sel)      din_d = sndmap_dout;
         else if (stat_sel) din_d = stat_byte(reply_q, sndmap_obf);
         else               din_d = 8'hFF;
      end
   end

   always_comb begin
      reply_d = reply_q;
      rep_d   = rep_q;
      if (data_wr) begin
         reply_d = 1'b1;
         rep_d   = z80_dout;
      end else if (data_rd) begin
         reply_d = 1'b0;
      end
   end

   // chk_q marks the first IDLE clock after an acknowledge, where a byte still
   // waiting (obf high) or one that arrived during ACK re-raises the interrupt.
   always_comb begin
      st_d    = st_q;
      rearm_d = rearm_q;
      chk_d   = chk_q;
      case (st_q)
         ST_IDLE: begin
            chk_d   = 1'b0;
            rearm_d = 1'b0;
            if (obf_rise | (chk_q & (sndmap_obf | rearm_q))) st_d = ST_PEND;
         end
         ST_PEND: begin
            if (inta_stb) begin
               st_d = ST_ACK;
               if (obf_rise) rearm_d = 1'b1;
            end else if (data_rd & ~obf_rise) begin
               st_d = ST_IDLE;
            end
         end
         ST_ACK: begin
            if (obf_rise) rearm_d = 1'b1;
            if (bus_idle) begin
               st_d  = ST_IDLE;
               chk_d = 1'b1;
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         obf_q   <= 1'b0;
         st_q    <= ST_IDLE;
         rearm_q <= 1'b0;
         chk_q   <= 1'b0;
         reply_q <= 1'b0;
         din_q   <= 8'd0;
         rep_q   <= 8'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         obf_q   <= sndmap_obf;
         st_q    <= st_d;
         rearm_q <= rearm_d;
         chk_q   <= chk_d;
         reply_q <= reply_d;
         din_q   <= din_d;
         rep_q   <= rep_d;
         rd_q    <= data_rd;
         wr_q    <= data_wr;
      end
   end

   assign sndmap_rd  = rd_q;
   assign sndmap_wr  = wr_q;
   assign sndmap_din = rep_q;
   assign z80_din    = din_q;
   assign z80_intn   = (st_q != ST_PEND);
   assign dbg_st_o   = st_q;

`ifdef SNDLATCH_NMI_EN
   logic [3:0] nmi_cnt_q, nmi_cnt_d;

   // A new byte restarts the pulse even if one is already running.
   always_comb begin
      nmi_cnt_d = nmi_cnt_q;
      if (obf_rise)                     nmi_cnt_d = NMI_LEN;
      else if (cen && nmi_cnt_q != 4'd0) nmi_cnt_d = nmi_cnt_q - 4'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) nmi_cnt_q <= 4'd0;
      else     nmi_cnt_q <= nmi_cnt_d;
   end

   assign z80_nmin = (nmi_cnt_q == 4'd0);
`else
   assign z80_nmin = 1'b1;
`endif

endmodule

// File: tb/tb_jts16b_sndlatch.sv
// Directed bench for jts16b_sndlatch: Z80 bus-cycle driver tasks, reply-byte
// scoreboard, pulse counters and a single checking task.
module tb_jts16b_sndlatch;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cen = 1'b0;
   logic       hold_cen = 1'b0;
   logic [7:0] sndmap_dout = 8'd0;
   logic       sndmap_obf = 1'b0;
   logic       sndmap_rd, sndmap_wr;
   logic [7:0] sndmap_din;
   logic [7:0] z80_addr = 8'd0;
   logic       z80_iorqn = 1'b1, z80_rdn = 1'b1, z80_wrn = 1'b1, z80_m1n = 1'b1;
   logic [7:0] z80_dout = 8'd0;
   logic [7:0] z80_din;
   logic       z80_intn, z80_nmin;
   logic [1:0] dbg_st;

   int n_chk  = 0;
   int n_pass = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   logic [7:0] exp_q[$];

   jts16b_sndlatch dut (
      .rst         (rst),
      .clk         (clk),
      .cen         (cen),
      .sndmap_dout (sndmap_dout),
      .sndmap_obf  (sndmap_obf),
      .sndmap_rd   (sndmap_rd),
      .sndmap_wr   (sndmap_wr),
      .sndmap_din  (sndmap_din),
      .z80_addr    (z80_addr),
      .z80_iorqn   (z80_iorqn),
      .z80_rdn     (z80_rdn),
      .z80_wrn     (z80_wrn),
      .z80_m1n     (z80_m1n),
      .z80_dout    (z80_dout),
      .z80_din     (z80_din),
      .z80_intn    (z80_intn),
      .z80_nmin    (z80_nmin),
      .dbg_st_o    (dbg_st)
   );

   // clock / reset block; cen toggles every clock unless held high
   always #5 clk = ~clk;
   always @(negedge clk) cen = hold_cen ? 1'b1 : ~cen;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // pulse counters and reply scoreboard, sampled just after the active edge
   always @(posedge clk) begin
      #1;
      if (sndmap_rd === 1'b1) rd_cnt++;
      if (sndmap_wr === 1'b1) begin
         wr_cnt++;
         if (exp_q.size() == 0) check("reply_spurious", 32'd1, 32'd0);
         else                   check("reply_byte", {24'd0, sndmap_din}, {24'd0, exp_q.pop_front()});
      end
   end

   // driver tasks: called and return on a falling edge
   task automatic io_rd(input logic [7:0] a);
      z80_addr = a; z80_iorqn = 1'b0; z80_rdn = 1'b0;
      repeat (6) @(negedge clk);
      z80_iorqn = 1'b1; z80_rdn = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
      if (a == 8'h40) exp_q.push_back(d);
      z80_addr = a; z80_dout = d; z80_iorqn = 1'b0; z80_wrn = 1'b0;
      repeat (6) @(negedge clk);
      z80_iorqn = 1'b1; z80_wrn = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic inta_begin();
      z80_m1n = 1'b0; z80_iorqn = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic inta_end();
      z80_m1n = 1'b1; z80_iorqn = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int n_low;
      repeat (3) @(negedge clk);
      check("rst_intn", z80_intn, 1);
      check("rst_nmin", z80_nmin, 1);
      check("rst_din", z80_din, 0);
      check("rst_rd", sndmap_rd, 0);
      check("rst_wr", sndmap_wr, 0);
      check("rst_repl", sndmap_din, 0);
      check("rst_st", dbg_st, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // byte arrives -> INT, acknowledge -> vector
      sndmap_dout = 8'h5A; sndmap_obf = 1'b1;
      @(negedge clk);
      check("intn_on_obf", z80_intn, 0);
      check("st_pend", dbg_st, 1);
      inta_begin();
      check("inta_vec", z80_din, 8'hFF);
      check("inta_intn", z80_intn, 1);
      check("st_ack", dbg_st, 2);
      inta_end();
      check("st_obf_still_high", dbg_st, 1);

      // data read consumes the byte
      rd_cnt = 0;
      io_rd(8'h40);
      check("rd_data", z80_din, 8'h5A);
      check("rd_pulse", rd_cnt, 1);
      check("rd_st_idle", dbg_st, 0);
      check("rd_intn", z80_intn, 1);
      sndmap_obf = 1'b0;
      @(negedge clk);

      // reply write and status
      rd_cnt = 0; wr_cnt = 0;
      io_wr(8'h40, 8'hC3);
      check("wr_pulse", wr_cnt, 1);
      check("wr_byte", sndmap_din, 8'hC3);
      io_rd(8'h41);
      check("stat_reply", z80_din, 8'h02);
      check("stat_no_rd", rd_cnt, 0);
      io_rd(8'h40);
      io_rd(8'h41);
      check("stat_clear", z80_din, 8'h00);
      io_rd(8'h55);
      check("rd_unmapped", z80_din, 8'hFF);
      wr_cnt = 0;
      io_wr(8'h55, 8'h11);
      check("wr_unmapped", wr_cnt, 0);
      check("repl_held", sndmap_din, 8'hC3);

      // byte arriving during ACK is not lost
      sndmap_dout = 8'hA6; sndmap_obf = 1'b1;
      @(negedge clk);
      inta_begin();
      sndmap_obf = 1'b0; @(negedge clk);
      sndmap_obf = 1'b1; @(negedge clk);
      sndmap_obf = 1'b0; @(negedge clk);
      check("ack_hold_st", dbg_st, 2);
      check("ack_hold_intn", z80_intn, 1);
      inta_end();
      check("rearm_st", dbg_st, 1);
      check("rearm_intn", z80_intn, 0);
      io_rd(8'h40);
      check("rearm_rd", z80_din, 8'hA6);
      check("rearm_idle", dbg_st, 0);

      // read and new-byte flag on the same clock, cen held high
      hold_cen = 1'b1;
      sndmap_dout = 8'h5A;
      repeat (2) @(negedge clk);
      rd_cnt = 0;
      z80_addr = 8'h40; z80_iorqn = 1'b0; z80_rdn = 1'b0; sndmap_obf = 1'b1;
      @(negedge clk);
      sndmap_dout = 8'h77;
      repeat (4) @(negedge clk);
      z80_iorqn = 1'b1; z80_rdn = 1'b1;
      repeat (2) @(negedge clk);
      check("same_clk_old", z80_din, 8'h5A);
      check("same_clk_pulse", rd_cnt, 1);
      check("same_clk_intn", z80_intn, 0);
      hold_cen = 1'b0;

      // reset in the middle of an access
      z80_addr = 8'h40; z80_iorqn = 1'b0; z80_rdn = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1; sndmap_obf = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_rst_din", z80_din, 0);
      check("mid_rst_intn", z80_intn, 1);
      check("mid_rst_st", dbg_st, 0);
      z80_iorqn = 1'b1; z80_rdn = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rd_cnt = 0;
      io_rd(8'h40);
      check("post_rst_rd", z80_din, 8'h77);
      check("post_rst_pulse", rd_cnt, 1);

      // NMI line
      hold_cen = 1'b1;
      repeat (2) @(negedge clk);
      sndmap_obf = 1'b1;
`ifdef SNDLATCH_NMI_EN
      n_low = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (z80_nmin == 1'b0) n_low++;
      end
      check("nmi_len", n_low, 8);
      sndmap_obf = 1'b0; @(negedge clk);
      sndmap_obf = 1'b1;
      repeat (2) @(negedge clk);
      check("nmi_low", z80_nmin, 0);
      rst = 1'b1;
      @(negedge clk);
      check("nmi_rst", z80_nmin, 1);
      rst = 1'b0;
`else
      n_low = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (z80_nmin == 1'b0) n_low++;
      end
      check("nmi_off", n_low, 0);
`endif
      hold_cen = 1'b0;
      repeat (4) @(negedge clk);

      check("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
